// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate-extension pipeline: extension modes and mode width.
package imm_ext_pkg;

  localparam int IMM_MODE_W = 2;

  typedef enum logic [IMM_MODE_W-1:0] {
    IMM_SIGN      = 2'd0,
    IMM_ZERO      = 2'd1,
    IMM_UPPER     = 2'd2,
    IMM_SIGN_SHL2 = 2'd3
  } imm_mode_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate formatter: raw immediate plus mode to extended word and its sign bit.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]       imm,
  input  logic [IMM_MODE_W-1:0] mode,
  output logic [OUT_W-1:0]      data,
  output logic                  neg
);

  logic [OUT_W-1:0] sext;

  assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

  always_comb begin
    data = sext;
    case (imm_mode_e'(mode))
      IMM_SIGN:      data = sext;
      IMM_ZERO:      data = {{(OUT_W-IN_W){1'b0}}, imm};
      IMM_UPPER:     data = {imm, {(OUT_W-IN_W){1'b0}}};
      // branch offsets: top two sign bits fall off the MSB end
      IMM_SIGN_SHL2: data = {sext[OUT_W-3:0], 2'b00};
      default:       data = sext;
    endcase
  end

  assign neg = data[OUT_W-1];

endmodule

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with valid/ready output register and result counter.
// Define IMM_EXT_PIPE_SKID_EN to add a one-entry skid register behind the output register.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       imm,
  input  logic [IMM_MODE_W-1:0] mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_neg,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      res_cnt
);

  generate
    if (OUT_W < IN_W + 2) begin : g_bad_width
      $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
    end
  endgenerate

  logic [OUT_W-1:0] fmt_data;
  logic             fmt_neg;
  logic             acc;
  logic             done;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (imm),
    .mode (mode),
    .data (fmt_data),
    .neg  (fmt_neg)
  );

  assign acc  = in_valid && in_ready;
  assign done = out_valid && out_ready;

`ifdef IMM_EXT_PIPE_SKID_EN
  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic             skid_neg;

  // in_ready comes straight from a flop, so out_ready never reaches upstream
  assign in_ready = !skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_neg    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_neg   <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_neg    <= skid_neg;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= acc;
        if (acc) begin
          out_data <= fmt_data;
          out_neg  <= fmt_neg;
        end
      end
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_data  <= fmt_data;
      skid_neg   <= fmt_neg;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_neg   <= 1'b0;
    end else if (in_ready) begin
      out_valid <= acc;
      if (acc) begin
        out_data <= fmt_data;
        out_neg  <= fmt_neg;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_cnt <= '0;
    end else if (cnt_clr) begin
      res_cnt <= '0;
    end else if (done) begin
      res_cnt <= res_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed mode vectors, stall/ordering, counter and reset cases,
// plus a randomized stream checked against a queue-based reference model.
module tb_imm_ext_pipe;

`ifdef IMM_EXT_PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready4;
  logic [15:0] imm;
  logic [1:0]  mode;
  logic        out_valid, out_valid4;
  logic        out_ready;
  logic [31:0] out_data, out_data4;
  logic        out_neg, out_neg4;
  logic        cnt_clr;
  logic [15:0] res_cnt;
  logic [3:0]  res_cnt4;

  always #5 clk = ~clk;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_neg(out_neg), .cnt_clr(cnt_clr), .res_cnt(res_cnt)
  );

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .imm(imm), .mode(mode), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .out_neg(out_neg4), .cnt_clr(cnt_clr), .res_cnt(res_cnt4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  int          exp_cnt = 0;

  bit          s_acc, s_done, s_rdy, s_ov, s_n, s_n4;
  logic [31:0] s_d, s_d4, s_exp;
  int          s_qsz;

  function automatic logic [31:0] ref_ext(input logic [15:0] im, input logic [1:0] md);
    longint s;
    s = longint'(im);
    if (im >= 16'h8000) s = s - 65536;
    case (md)
      2'd0:    return 32'(s & 64'hFFFF_FFFF);
      2'd1:    return 32'(im);
      2'd2:    return 32'(longint'(im) * 65536);
      default: return 32'((s * 4) & 64'hFFFF_FFFF);
    endcase
  endfunction

  // One clock cycle: drive, observe the handshakes before the edge, update the model.
  // Entered and left at 1 time unit after a rising edge.
  task automatic step(input bit v, input logic [15:0] im, input logic [1:0] md,
                      input bit ordy, input bit clr);
    in_valid = v; imm = im; mode = md; out_ready = ordy; cnt_clr = clr;
    #3;
    s_qsz  = exp_q.size();
    s_rdy  = in_ready;
    s_ov   = out_valid;
    s_acc  = in_valid && in_ready;
    s_done = out_valid && out_ready;
    s_d = out_data; s_n = out_neg; s_d4 = out_data4; s_n4 = out_neg4;
    s_exp = 'x;
    if (s_done && exp_q.size() > 0) s_exp = exp_q.pop_front();
    if (s_acc) exp_q.push_back(ref_ext(im, md));
    if (clr) exp_cnt = 0;
    else if (s_done) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; imm = '0; mode = '0; out_ready = 0; cnt_clr = 0;
    #2;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_tests++; if (out_neg !== 1'b0) begin n_fail++; $display("FAIL reset_out_neg got %b want 0", out_neg); end
    n_tests++; if (res_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_res_cnt got %0d want 0", res_cnt); end
    @(posedge clk); #3; rst_n = 1'b1; #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_modes();
    logic [15:0] v_imm [5] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h4000};
    logic [1:0]  v_md  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [31:0] v_exp [5] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC, 32'h00010000};
    for (int i = 0; i < 5; i++) begin
      step(1, v_imm[i], v_md[i], 1, 0);
      n_tests++; if (!s_acc) begin n_fail++; $display("FAIL mode%0d_accept got 0 want 1", i); end
      n_tests++; if (out_valid !== 1'b1 || out_data !== v_exp[i] || out_neg !== v_exp[i][31]) begin
        n_fail++; $display("FAIL mode%0d_result got v=%b d=%h n=%b want v=1 d=%h n=%b",
                           i, out_valid, out_data, out_neg, v_exp[i], v_exp[i][31]);
      end
      step(0, '0, '0, 1, 0);
      n_tests++; if (!s_done || s_d !== s_exp) begin
        n_fail++; $display("FAIL mode%0d_drain got done=%b d=%h want done=1 d=%h", i, s_done, s_d, s_exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] it_imm [3];
    logic [1:0]  it_md  [3];
    int idx = 0, outs = 0;
    for (int i = 0; i < 3; i++) begin
      it_imm[i] = 16'($urandom_range(0, 65535));
      it_md[i]  = 2'($urandom_range(0, 3));
    end
    for (int c = 0; c < 3; c++) begin
      step(1, it_imm[idx], it_md[idx], 0, 0);
      if (s_acc) idx++;
    end
    n_tests++; if (idx != CAP) begin n_fail++; $display("FAIL b2b_accepted got %0d want %0d", idx, CAP); end
    n_tests++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready_stalled got %b want 0", s_rdy); end
    for (int c = 0; c < 20 && outs < 3; c++) begin
      step(idx < 3, it_imm[idx < 3 ? idx : 0], it_md[idx < 3 ? idx : 0], 1, 0);
      if (s_acc) idx++;
      if (s_done) begin
        n_tests++; if (s_d !== ref_ext(it_imm[outs], it_md[outs]) || s_d !== s_exp) begin
          n_fail++; $display("FAIL b2b_order item%0d got %h want %h", outs, s_d, ref_ext(it_imm[outs], it_md[outs]));
        end
        outs++;
      end
    end
    n_tests++; if (outs != 3) begin n_fail++; $display("FAIL b2b_timeout got %0d outputs want 3", outs); end
  endtask

  task automatic test_stream();
    step(0, '0, '0, 1, 1);
    for (int i = 0; i < 11; i++) begin
      step(i < 10, 16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)), 1, 0);
      if (i < 10) begin
        n_tests++; if (!s_acc) begin n_fail++; $display("FAIL stream_accept%0d got 0 want 1", i); end
      end
      if (i > 0) begin
        n_tests++; if (!s_done || s_d !== s_exp || s_n !== s_exp[31]) begin
          n_fail++; $display("FAIL stream_out%0d got done=%b d=%h want done=1 d=%h", i, s_done, s_d, s_exp);
        end
      end
    end
    n_tests++; if (res_cnt !== 16'd10) begin n_fail++; $display("FAIL stream_res_cnt got %0d want 10", res_cnt); end
  endtask

  task automatic test_counter();
    step(0, '0, '0, 1, 1);
    for (int i = 0; i < 18; i++) step(i < 17, 16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)), 1, 0);
    n_tests++; if (res_cnt4 !== 4'd1) begin n_fail++; $display("FAIL wrap_res_cnt4 got %0d want 1", res_cnt4); end
    n_tests++; if (res_cnt !== 16'd17) begin n_fail++; $display("FAIL wrap_res_cnt got %0d want 17", res_cnt); end
    step(1, 16'h00AA, 2'd1, 1, 0);
    step(0, '0, '0, 1, 1);
    n_tests++; if (!s_done) begin n_fail++; $display("FAIL clr_completion got done=0 want 1"); end
    n_tests++; if (res_cnt !== 16'd0 || res_cnt4 !== 4'd0) begin
      n_fail++; $display("FAIL clr_priority got %0d/%0d want 0/0", res_cnt, res_cnt4);
    end
  endtask

  task automatic test_random();
    bit ordy;
    for (int c = 0; c < 300; c++) begin
      ordy = ($urandom_range(0, 9) < 7);
      step($urandom_range(0, 3) != 0, 16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)),
           ordy, $urandom_range(0, 49) == 0);
      n_tests++; if (s_ov !== (s_qsz > 0)) begin
        n_fail++; $display("FAIL rnd_out_valid cyc%0d got %b want %b", c, s_ov, s_qsz > 0);
      end
      n_tests++; if (s_rdy !== ((CAP == 2) ? (s_qsz < 2) : (s_qsz == 0 || ordy))) begin
        n_fail++; $display("FAIL rnd_in_ready cyc%0d got %b (pending %0d)", c, s_rdy, s_qsz);
      end
      if (s_done) begin
        n_tests++; if (s_d !== s_exp || s_n !== s_exp[31] || s_d4 !== s_exp || s_n4 !== s_exp[31]) begin
          n_fail++; $display("FAIL rnd_data cyc%0d got %h/%h want %h", c, s_d, s_d4, s_exp);
        end
      end
      n_tests++; if (res_cnt !== 16'(exp_cnt) || res_cnt4 !== 4'(exp_cnt)) begin
        n_fail++; $display("FAIL rnd_res_cnt cyc%0d got %0d/%0d want %0d", c, res_cnt, res_cnt4, exp_cnt);
      end
    end
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      step(0, '0, '0, 1, 0);
      if (s_done) begin
        n_tests++; if (s_d !== s_exp) begin n_fail++; $display("FAIL rnd_drain got %h want %h", s_d, s_exp); end
      end
    end
    n_tests++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rnd_drain_empty got pending=%0d out_valid=%b want 0/0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] c_imm;
    step(1, 16'h0123, 2'd0, 1, 0);
    step(1, 16'h8000, 2'd0, 0, 0);
    step(1, 16'h7FFF, 2'd3, 0, 0);
    n_tests++; if (out_valid !== 1'b1 || res_cnt === 16'd0) begin
      n_fail++; $display("FAIL rstmid_pre got out_valid=%b res_cnt=%0d want 1 and nonzero", out_valid, res_cnt);
    end
    in_valid = 0; out_ready = 1; rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0 || res_cnt !== 16'd0 || res_cnt4 !== 4'd0) begin
      n_fail++; $display("FAIL rstmid_clear got v=%b cnt=%0d want 0/0", out_valid, res_cnt);
    end
    exp_q.delete(); exp_cnt = 0;
    #1; rst_n = 1'b1; #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0 || res_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_post got v=%b cnt=%0d want 0/0", out_valid, res_cnt);
    end
    c_imm = 16'($urandom_range(0, 65535));
    step(1, c_imm, 2'd0, 1, 0);
    n_tests++; if (!s_acc || out_valid !== 1'b1 || out_data !== ref_ext(c_imm, 2'd0)) begin
      n_fail++; $display("FAIL rstmid_next got v=%b d=%h want v=1 d=%h", out_valid, out_data, ref_ext(c_imm, 2'd0));
    end
    step(0, '0, '0, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_stream();
    test_counter();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, pipelined immediate-extension unit for the datapath's decode stage. It replaces the fixed 16→32 combinational sign extender and adds:
- configurable input/output widths
- four extension modes (sign, zero, upper/LUI, sign-shift-left-2 for branch offsets)
- a registered valid/ready output stage with optional skid buffer
- a wrapping count of delivered results

It sits between the instruction register and the ALU-B mux / branch adder.

## Interface
Parameters:
- IN_W, default 16: immediate input width.
- OUT_W, default 32: extended output width; must satisfy OUT_W ≥ IN_W+2 (elaboration error otherwise).
- CNT_W, default 16: width of the delivered-result counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents imm/mode.
- in_ready  out  1  unit can accept this cycle.
- imm  in  IN_W  raw immediate.
- mode  in  2  extension mode, see Operation.
- out_valid  out  1  out_data holds a valid result.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  OUT_W  extended result.
- out_neg  out  1  MSB of out_data, registered with out_data.
- cnt_clr  in  1  synchronous clear of the result counter.
- res_cnt  out  CNT_W  number of completed output handshakes, modulo 2^CNT_W.

## Operation
Modes (mode[1:0]):
- 0 SIGN: imm[IN_W-1] replicated into out_data[OUT_W-1:IN_W]; out_data[IN_W-1:0]=imm.
- 1 ZERO: upper bits zero; out_data[IN_W-1:0]=imm.
- 2 UPPER: out_data[OUT_W-1:OUT_W-IN_W]=imm; lower OUT_W-IN_W bits zero.
- 3 SIGN_SHL2: the SIGN result shifted left by 2, with the two LSBs zero. Bits shifted out of the MSB end are discarded.

Handshake and ordering:
- An input is accepted when in_valid && in_ready. An output completes when out_valid && out_ready.
- Results leave strictly in acceptance order. No drop, no duplication.
- mode and imm are sampled only on acceptance. Values while in_valid=0 are ignored.

Counter:
- res_cnt increments by 1 on each completed output and wraps from all-ones to 0.
- cnt_clr takes priority: clear together with a completing output yields res_cnt=0.

## Timing
- Latency: an input accepted in cycle N produces out_valid=1 in cycle N+1 with the matching out_data and out_neg.
- Throughput: 1 result per cycle while out_ready=1.
- Reset values (asynchronous, on rst_n low): out_valid=0, out_data=0, out_neg=0, res_cnt=0, skid empty. in_ready=1 once rst_n is high.
- Output stall: out_data and out_neg hold stable while out_valid=1 && out_ready=0.
- Accept and complete in the same cycle: the output register reloads with the new result; out_valid stays 1.
- Reset asserted mid-transfer: all in-flight results are discarded. No output handshake completes in the reset cycle.

## Configuration
- Macro: IMM_EXT_PIPE_SKID_EN.
- Defined: a one-entry skid register sits behind the output register.
  - in_ready is a registered signal equal to "skid empty", with no combinational path from out_ready.
  - An input accepted while the output is stalled goes to the skid register. in_ready drops the next cycle.
  - When the output drains, the skid entry moves to the output register and in_ready returns to 1 the following cycle.
  - Capacity: 2 results (output register plus skid).
- Undefined: there is no skid register, and in_ready = !out_valid || out_ready, combinationally. Capacity is 1 result.

## Structure
- Package imm_ext_pkg holds the mode enum (IMM_SIGN, IMM_ZERO, IMM_UPPER, IMM_SIGN_SHL2) and the mode width constant (2).
- Sub-module imm_ext_core is the purely combinational formatter: imm, mode → data, neg. It is instantiated once on the input side, so both the output register and the skid register store finished results.
- The top level contains only handshake control, registers and the counter.

## Test plan
Parameters for all scenarios: IN_W=16, OUT_W=32.
- SIGN, imm=0x8001 → out_data=0xFFFF8001, out_neg=1, one cycle after accept. ZERO with the same imm → 0x00008001, out_neg=0.
- UPPER, imm=0x1234 → 0x12340000. SIGN_SHL2, imm=0xFFFF → 0xFFFFFFFC. SIGN_SHL2, imm=0x4000 → 0x00010000.
- Stream A,B,C back-to-back with out_ready=0 for 3 cycles:
  - SKID_EN: A and B accepted, in_ready=0 from the cycle after B's accept, C held upstream; after release the outputs are A,B,C in order.
  - Without SKID_EN: only A accepted.
- Continuous in_valid/out_ready=1 for 10 items → 10 outputs in consecutive cycles; res_cnt=10.
- CNT_W=4 with 17 completions → res_cnt=1. cnt_clr asserted in the same cycle as a completion → res_cnt=0 the next cycle.
- rst_n pulsed low while out_valid=1 and the skid is full → out_valid=0 and res_cnt=0 immediately; in_ready=1 after release; the next input's result is correct after 1 cycle.
